// File: rtl/snake_dir_if.sv
// snake_dir_if -- key-event / movement-command bundle between the keyboard
// side, snake_dir_ctrl and the game core.
//   key_code  [7:0]  decoded key value from the keyboard driver
//   key_state        level, 1 while a key is held
//   tick             one-cycle game-step strobe
//   dir       [1:0]  committed direction (0 up, 1 right, 2 down, 3 left)
//   step             one-cycle advance pulse
//   paused           pause flag
//   restart          one-cycle restart pulse
//   q_count   [2:0]  pending turns in the FIFO
// master: stimulus / keyboard side.  slave: snake_dir_ctrl.
interface snake_dir_if;
  logic [7:0] key_code;
  logic       key_state;
  logic       tick;
  logic [1:0] dir;
  logic       step;
  logic       paused;
  logic       restart;
  logic [2:0] q_count;

  modport master (
    output key_code, key_state, tick,
    input  dir, step, paused, restart, q_count
  );

  modport slave (
    input  key_code, key_state, tick,
    output dir, step, paused, restart, q_count
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl -- turns keyboard events into snake movement commands.
// Key inputs are registered once, then edge/code-change detected to form a
// one-cycle press. Arrow keys queue turns in a small circular FIFO (reversals,
// duplicates and overflow are dropped); each unpaused tick emits step and
// pops one turn into dir. 'P' toggles pause, 'R' restarts (highest priority).
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    snake_dir_if.slave (key_code/key_state/tick in,
//          dir/step/paused/restart/q_count out)
// Parameters: DEPTH (1..4) turn FIFO depth, INIT_DIR direction after
// reset/restart.
// Build option: define SNAKE_WASD_EN to also steer with W/A/S/D.
module snake_dir_ctrl #(
  parameter int         DEPTH    = 2,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input logic        clk,
  input logic        rst_n,
  snake_dir_if.slave bus
);

  localparam logic [1:0] PTR_MAX = 2'(DEPTH - 1);
  localparam logic [2:0] FULL    = 3'(DEPTH);

  // Input sample stage plus the previous-cycle copy used for edge detection.
  logic [7:0] code_r, code_prev;
  logic       state_r, state_prev;

  // Turn FIFO: storage is always 4 entries, only DEPTH of them are used.
  logic [1:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;

  logic [1:0] dir;
  logic       step, paused, restart;

  logic       press, is_dir, is_pause, is_rst;
  logic [1:0] new_dir, ref_dir, tail;
  logic       push, pop, tick_go;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_MAX) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] ptr_dec(input logic [1:0] p);
    return (p == 2'd0) ? PTR_MAX : p - 2'd1;
  endfunction

  // A new key going down, or a different key showing while one is held.
  assign press = state_r & (~state_prev | (code_r != code_prev));

  always_comb begin
    is_dir   = 1'b0;
    new_dir  = 2'd0;
    is_pause = 1'b0;
    is_rst   = 1'b0;
    case (code_r)
      8'h18: begin is_dir = 1'b1; new_dir = 2'd0; end
      8'h1A: begin is_dir = 1'b1; new_dir = 2'd1; end
      8'h19: begin is_dir = 1'b1; new_dir = 2'd2; end
      8'h1B: begin is_dir = 1'b1; new_dir = 2'd3; end
`ifdef SNAKE_WASD_EN
      8'h57: begin is_dir = 1'b1; new_dir = 2'd0; end
      8'h44: begin is_dir = 1'b1; new_dir = 2'd1; end
      8'h53: begin is_dir = 1'b1; new_dir = 2'd2; end
      8'h41: begin is_dir = 1'b1; new_dir = 2'd3; end
`endif
      8'h50: is_pause = 1'b1;
      8'h52: is_rst   = 1'b1;
      default: ;
    endcase
  end

  // Compare against the last queued turn so chained turns are checked
  // against where the snake will be heading, not where it heads now.
  assign tail    = mem[ptr_dec(wr_ptr)];
  assign ref_dir = (count != 3'd0) ? tail : dir;

  // Opposite directions differ only in bit 1 with this encoding.
  assign push = press & is_dir & (new_dir != ref_dir) &
                ((new_dir ^ ref_dir) != 2'b10) & (count != FULL);
  assign tick_go = bus.tick & ~paused;
  assign pop     = tick_go & (count != 3'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_r     <= 8'h00;
      code_prev  <= 8'h00;
      state_r    <= 1'b0;
      state_prev <= 1'b0;
      rd_ptr     <= 2'd0;
      wr_ptr     <= 2'd0;
      count      <= 3'd0;
      dir        <= INIT_DIR;
      step       <= 1'b0;
      paused     <= 1'b0;
      restart    <= 1'b0;
    end else begin
      code_r     <= bus.key_code;
      state_r    <= bus.key_state;
      code_prev  <= code_r;
      state_prev <= state_r;
      step       <= 1'b0;
      restart    <= 1'b0;
      if (press && is_rst) begin
        // Restart swallows any tick landing in the same cycle.
        restart <= 1'b1;
        rd_ptr  <= 2'd0;
        wr_ptr  <= 2'd0;
        count   <= 3'd0;
        dir     <= INIT_DIR;
        paused  <= 1'b0;
      end else begin
        if (press && is_pause) paused <= ~paused;
        step <= tick_go;
        if (pop) begin
          dir    <= mem[rd_ptr];
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push) begin
          mem[wr_ptr] <= new_dir;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  assign bus.dir     = dir;
  assign bus.step    = step;
  assign bus.paused  = paused;
  assign bus.restart = restart;
  assign bus.q_count = count;

endmodule
